ta_sync_sched: RTL
==================

Name: ta_sync_sched

Overview:
- Sequencer for the sync-trigger / capture / laser-driver chain in the clk50 domain.
- On a start command it runs a sweep of acquisitions:
  - Each acquisition is one one-cycle sync_trig pulse, handshaked against syncr_rdy.
  - cap_phase is stepped from phase_first to phase_last.
  - frame_num frames are taken at each phase.
- Reports busy/done/timeout status and progress counters to the register block.

Parameters:
- CAP0_1, 2, width of cap_phase; must match the trigger block.
- FRM_W, 16, width of frame count configuration and counters.
- TO_W, 20, width of the run-timeout counter.
- ACK_TO, 8, cycles allowed for syncr_rdy to fall after sync_trig.

Ports:
- clk50  in  1  single clock for all logic.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle sweep start; ignored unless IDLE or DONE.
- abort  in  1  level or pulse; forces return to IDLE.
- phase_first  in  CAP0_1  first capture phase; sampled on accepted start.
- phase_last  in  CAP0_1  last capture phase; sampled on accepted start.
- frame_num  in  FRM_W  frames per phase; sampled on start; 0 treated as 1.
- gap_cyc  in  16  idle cycles between acquisitions; sampled on start.
- run_to  in  TO_W  max cycles waiting for syncr_rdy to return; 0 = no timeout.
- syncr_rdy  in  1  high when the trigger chain is ready.
- sync_trig  out  1  one-cycle trigger pulse to the trigger block.
- cap_phase  out  CAP0_1  phase for current acquisition; stable from trigger to completion.
- busy  out  1  high in any state other than IDLE/DONE.
- done  out  1  high in DONE; cleared by start or abort.
- err_to  out  1  sticky timeout flag; cleared by accepted start or reset.
- frame_cnt  out  FRM_W  frames completed at current phase.
- acq_cnt  out  FRM_W+CAP0_1  total acquisitions completed in this sweep.

Behaviour:
Reset values (async rst, all registers): state=IDLE, sync_trig=0, cap_phase=0, busy=0, done=0, err_to=0, frame_cnt=0, acq_cnt=0.

States and transitions:
- IDLE/DONE: accepted start latches config, sets cap_phase=phase_first, clears counters and err_to, goes to ARM next cycle.
- ARM: wait for syncr_rdy=1. On the cycle syncr_rdy is sampled high, go to TRIG.
- TRIG: sync_trig=1 for exactly this cycle, then go to WACK with the timer loaded.
- WACK: wait for syncr_rdy=0. If ACK_TO cycles elapse first, set err_to and go to DONE.
- WRUN: wait for syncr_rdy=1, meaning the acquisition is complete.
  - On completion: frame_cnt+1, acq_cnt+1.
  - If run_to!=0 and run_to cycles elapse first: err_to=1, go to DONE.
- GAP: count gap_cyc cycles (0 = skip, one cycle minimum in state), then advance:
  - If frame_cnt<frame_num: go to ARM.
  - Else if cap_phase!=phase_last: frame_cnt=0, cap_phase+1 (wraps modulo 2^CAP0_1), go to ARM.
  - Else go to DONE.
- DONE: done=1. Reachable from GAP (normal end) or on timeout.

Phase and counter rules:
- cap_phase changes only in GAP.
- If phase_first>phase_last, phases wrap through 0. Example: 3,0,1 for first=3, last=1.
- Minimum latency: start to sync_trig is 2 cycles when syncr_rdy is already high.
- acq_cnt saturates at all-ones.

Abort and mid-operation events:
- abort has priority in every state: next cycle IDLE, sync_trig=0, done=0; counters and err_to hold.
- If abort coincides with start, abort wins.
- If syncr_rdy rises in the same cycle a timeout expires, completion wins.
- start while busy is ignored.
- rst asserted mid-sweep returns all outputs to reset values immediately.

Test Plan:
- Basic sweep: phase_first=0, phase_last=3, frame_num=2, gap_cyc=0, ideal responder (rdy low 1 cycle after trig, high after 10) -> 8 sync_trig pulses; cap_phase sequence 0,0,1,1,2,2,3,3; acq_cnt=8; done=1; err_to=0.
- Wrap and zero frames: phase_first=3, phase_last=1, frame_num=0 -> 3 pulses at phases 3,0,1; acq_cnt=3.
- Ack timeout: syncr_rdy held high -> err_to=1 and DONE reached ACK_TO cycles after trigger; exactly one pulse issued.
- Run timeout: run_to=50, responder never reasserts -> err_to=1 after 50 cycles in WRUN; with run_to=0 the block waits indefinitely.
- Abort mid-WRUN after 5 acquisitions -> IDLE next cycle; busy=0, done=0; acq_cnt holds 5; new start restarts from phase_first with acq_cnt=0.
- Async reset mid-TRIG -> sync_trig and busy drop without a clock edge; start during busy ignored; gap_cyc=4 gives exactly 4 cycles of spacing in GAP before ARM.

Source files
------------

// File: rtl/ta_sync_sched.sv
// Sweep sequencer for the sync-trigger / capture / laser-driver chain (clk50 domain).
// Steps cap_phase across a range, taking frame_num handshaked acquisitions per phase.
module ta_sync_sched #(
  parameter int unsigned CAP0_1 = 2,
  parameter int unsigned FRM_W  = 16,
  parameter int unsigned TO_W   = 20,
  parameter int unsigned ACK_TO = 8
) (
  input  logic                      clk50,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      abort,
  input  logic [CAP0_1-1:0]         phase_first,
  input  logic [CAP0_1-1:0]         phase_last,
  input  logic [FRM_W-1:0]          frame_num,
  input  logic [15:0]               gap_cyc,
  input  logic [TO_W-1:0]           run_to,
  input  logic                      syncr_rdy,
  output logic                      sync_trig,
  output logic [CAP0_1-1:0]         cap_phase,
  output logic                      busy,
  output logic                      done,
  output logic                      err_to,
  output logic [FRM_W-1:0]          frame_cnt,
  output logic [FRM_W+CAP0_1-1:0]   acq_cnt
);

  typedef enum logic [2:0] {
    S_IDLE, S_ARM, S_TRIG, S_WACK, S_WRUN, S_GAP, S_DONE
  } state_t;

  // The trigger cycle counts toward the ack window, so WACK times out on ACK_TO-1.
  localparam logic [TO_W-1:0] ACK_LIM = TO_W'((ACK_TO > 0) ? ACK_TO - 1 : 0);

  state_t                    state, state_d;
  logic [TO_W-1:0]           tmr, tmr_d;
  logic [CAP0_1-1:0]         cap_phase_d;
  logic [FRM_W-1:0]          frame_cnt_d;
  logic [FRM_W+CAP0_1-1:0]   acq_cnt_d;
  logic                      err_to_d;
  logic                      ld_cfg;

  logic [CAP0_1-1:0]         last_r;
  logic [FRM_W-1:0]          frm_r;
  logic [15:0]               gap_r;
  logic [TO_W-1:0]           run_to_r;

  assign sync_trig = (state == S_TRIG);
  assign busy      = (state != S_IDLE) && (state != S_DONE);
  assign done      = (state == S_DONE);

  always_ff @(posedge clk50 or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      tmr       <= '0;
      cap_phase <= '0;
      frame_cnt <= '0;
      acq_cnt   <= '0;
      err_to    <= 1'b0;
    end else begin
      state     <= state_d;
      tmr       <= tmr_d;
      cap_phase <= cap_phase_d;
      frame_cnt <= frame_cnt_d;
      acq_cnt   <= acq_cnt_d;
      err_to    <= err_to_d;
    end
  end

  always_ff @(posedge clk50 or posedge rst) begin
    if (rst) begin
      last_r   <= '0;
      frm_r    <= '0;
      gap_r    <= '0;
      run_to_r <= '0;
    end else if (ld_cfg) begin
      last_r   <= phase_last;
      frm_r    <= (frame_num == '0) ? FRM_W'(1) : frame_num;
      gap_r    <= gap_cyc;
      run_to_r <= run_to;
    end
  end

  always_comb begin
    state_d     = state;
    tmr_d       = tmr;
    cap_phase_d = cap_phase;
    frame_cnt_d = frame_cnt;
    acq_cnt_d   = acq_cnt;
    err_to_d    = err_to;
    ld_cfg      = 1'b0;
    if (abort) begin
      state_d = S_IDLE;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            ld_cfg      = 1'b1;
            cap_phase_d = phase_first;
            frame_cnt_d = '0;
            acq_cnt_d   = '0;
            err_to_d    = 1'b0;
            state_d     = S_ARM;
          end
        end
        S_ARM: begin
          if (syncr_rdy) state_d = S_TRIG;
        end
        S_TRIG: begin
          tmr_d   = TO_W'(1);
          state_d = S_WACK;
        end
        S_WACK: begin
          if (!syncr_rdy) begin
            tmr_d   = '0;
            state_d = S_WRUN;
          end else if (tmr >= ACK_LIM) begin
            err_to_d = 1'b1;
            state_d  = S_DONE;
          end else begin
            tmr_d = tmr + 1'b1;
          end
        end
        S_WRUN: begin
          // Completion is tested first so it wins over a coincident timeout.
          if (syncr_rdy) begin
            frame_cnt_d = frame_cnt + 1'b1;
            if (acq_cnt != '1) acq_cnt_d = acq_cnt + 1'b1;
            tmr_d   = '0;
            state_d = S_GAP;
          end else if ((run_to_r != '0) && (tmr == run_to_r - 1'b1)) begin
            err_to_d = 1'b1;
            state_d  = S_DONE;
          end else begin
            tmr_d = tmr + 1'b1;
          end
        end
        S_GAP: begin
          if ((gap_r == '0) || (tmr[15:0] == gap_r - 16'd1)) begin
            tmr_d = '0;
            if (frame_cnt < frm_r) begin
              state_d = S_ARM;
            end else if (cap_phase != last_r) begin
              frame_cnt_d = '0;
              cap_phase_d = cap_phase + 1'b1;
              state_d     = S_ARM;
            end else begin
              state_d = S_DONE;
            end
          end else begin
            tmr_d = tmr + 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

endmodule
